alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Downstream capture stage for the combinational ALU's 64-bit C output.
- Latches the result into the ZHI/ZLO pair on control-unit command. For mul/div it waits a fixed settle time before capturing, then also commits HI/LO.
- Drives the selected Z/HI/LO word onto the 32-bit datapath bus for writeback and mfhi/mflo.

Parameters:
- MULDIV_WAIT, 4, edges between issue and capture for mul/div, giving the deep combinational mul/div time to settle; legal range 1..15.
- OPW, 5, opcode width; matches the ALU opcode field.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-low reset.
- issue  in  1  capture request; sampled each rising edge.
- opcode  in  OPW  ALU opcode; valid when issue=1.
- c_in  in  64  ALU C output; must be stable at the capture edge.
- busy  out  1  high while waiting on a mul/div.
- done  out  1  one-cycle pulse after each completed issue.
- issue_drop  out  1  one-cycle pulse when an issue is ignored because busy.
- zhi  out  32  Z register upper word.
- zlo  out  32  Z register lower word.
- hi  out  32  HI register.
- lo  out  32  LO register.
- zlo_oe, zhi_oe, lo_oe, hi_oe  in  1 each  bus drive selects.
- bus_out  out  32  selected word.
- bus_drv  out  1  high when any select is asserted.

Behaviour:
- Single clock. Reset is synchronous and active-low: clr=0 at a rising edge resets everything.
- Reset values: state=IDLE, zhi/zlo/hi/lo=0, busy/done/issue_drop=0, counter=0, latched opcode=0.
- Reset mid-WAIT: abort with no capture; done does not pulse.
- FSM has two states, IDLE and WAIT. busy = (state==WAIT), decoded from the state register only.
- IDLE, issue=1, opcode is mul (01110) or div (01111):
  - latch opcode; load counter with MULDIV_WAIT-1; go to WAIT.
  - c_in is not sampled on this edge.
- IDLE, issue=1, opcode nop (11001) or halt (11010): no register change; done=1 next cycle.
- IDLE, issue=1, any other opcode:
  - {zhi,zlo} <= c_in on the same edge; done=1 next cycle.
  - Zero-cycle capture latency: the result is visible on zhi/zlo in the cycle after issue.
- WAIT, counter != 0: counter decrements.
- WAIT, counter == 0:
  - {zhi,zlo} <= c_in; hi <= c_in[63:32]; lo <= c_in[31:0].
  - Return to IDLE; done=1 next cycle.
  - Capture happens on edge E0+MULDIV_WAIT, where E0 is the issue edge.
- Div packing: remainder in [63:32] goes to HI; quotient in [31:0] goes to LO.
- HI/LO change only on mul/div capture. Non-mul/div ops never touch them.
- issue=1 while in WAIT: ignored, with no state or counter change; issue_drop=1 next cycle.
- Upstream holds Y/B/opcode stable for the whole WAIT window.
- The same issue as a capture edge is legal only from IDLE. After completion, a new issue is accepted on the edge following the capture edge.
- done and issue_drop are registered single-cycle pulses. They are never high for two consecutive cycles from one event.
- Bus mux (combinational), priority zlo_oe > zhi_oe > lo_oe > hi_oe:
  - bus_out = the selected word, or 0 if none is selected.
  - bus_drv = OR of the selects.
  - Multiple selects resolve by priority; this is not an error.
- Bus reads see register contents from before the edge. A same-cycle capture is visible on the next cycle.

Optional Feature:
- Macro: ALU_RESULT_ZFLAG_EN.
- Defined: adds output zflag (1 bit) and output nflag (1 bit), updated on every Z capture and left unchanged otherwise:
  - zflag = (c_in == 0) over all 64 bits.
  - nflag = c_in[31] for non-mul/div ops, c_in[63] for mul/div.
  - Both reset to 0.
- Undefined: neither port exists and no flag logic is generated.

Test Plan:
- Reset, then add: clr=0 for 2 cycles with issue=1 -> all outputs 0. Release; issue add, c_in=64'h0000_0000_0000_0007 -> zlo=7, zhi=0, done pulses 1 cycle, busy never high, hi/lo stay 0.
- Mul with default MULDIV_WAIT=4: issue opcode 01110 at E0, c_in=64'h0000_0001_0000_0002 by E4 -> busy high E0..E4, capture at E4, hi=1, lo=2, zhi=1, zlo=2, done at E4+1.
- Issue while busy: div issued, second issue (add) at E2 -> issue_drop pulse after E2, Z/HI/LO unaffected by add, div completes at E4 with hi=rem, lo=quot.
- Reset mid-WAIT: mul issued, clr=0 at E2 -> state IDLE, hi=lo=0, no done pulse; next add issue captured normally.
- Bus mux: zlo=5, hi=9. Assert hi_oe only -> bus_out=9, bus_drv=1. Assert zlo_oe+hi_oe -> bus_out=5. No selects -> bus_out=0, bus_drv=0.
- nop/halt and ZFLAG: issue nop -> Z unchanged, done pulses. With ALU_RESULT_ZFLAG_EN, issue sub with c_in=0 -> zflag=1. Issue add with c_in=32'h8000_0000 -> nflag=1, zflag=0.

Source files
------------

// File: rtl/alu_result_stage.sv
// alu_result_stage: capture stage behind the combinational ALU.
// Ordinary ops land in ZHI/ZLO on the issue edge. mul/div first wait
// MULDIV_WAIT edges for the deep multiplier/divider to settle, then
// update ZHI/ZLO and HI/LO together. A priority mux drives one of the
// four result words onto the 32-bit datapath bus.
// Optional build macro: ALU_RESULT_ZFLAG_EN adds zflag/nflag outputs.
module alu_result_stage #(
  parameter int MULDIV_WAIT = 4,
  parameter int OPW         = 5
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           issue,
  input  logic [OPW-1:0] opcode,
  input  logic [63:0]    c_in,
  output logic           busy,
  output logic           done,
  output logic           issue_drop,
  output logic [31:0]    zhi,
  output logic [31:0]    zlo,
  output logic [31:0]    hi,
  output logic [31:0]    lo,
  input  logic           zlo_oe,
  input  logic           zhi_oe,
  input  logic           lo_oe,
  input  logic           hi_oe,
  output logic [31:0]    bus_out,
  output logic           bus_drv
`ifdef ALU_RESULT_ZFLAG_EN
  ,
  output logic           zflag,
  output logic           nflag
`endif
);

  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11001);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11010);

  // Four bits cover the whole 1..15 settle range.
  localparam logic [3:0] CNT_LOAD = 4'(MULDIV_WAIT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t         state_q;
  logic [3:0]     cnt_q;
  logic [OPW-1:0] opLatched_q;
  logic [31:0]    zhi_q;
  logic [31:0]    zlo_q;
  logic [31:0]    hi_q;
  logic [31:0]    lo_q;
  logic           done_q;
  logic           drop_q;
`ifdef ALU_RESULT_ZFLAG_EN
  logic           zflag_q;
  logic           nflag_q;
`endif

  logic issueMulDiv;
  logic issueNoCapture;
  logic latchedMulDiv;

  assign issueMulDiv    = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign issueNoCapture = (opcode == OP_NOP) || (opcode == OP_HALT);
  // The latched opcode guards the HI/LO commit so only a genuine mul/div
  // that entered WAIT can ever write them.
  assign latchedMulDiv  = (opLatched_q == OP_MUL) || (opLatched_q == OP_DIV);

  // Capture FSM: result registers, settle counter and the done/drop pulses.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      opLatched_q <= '0;
      zhi_q       <= 32'd0;
      zlo_q       <= 32'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
`ifdef ALU_RESULT_ZFLAG_EN
      zflag_q     <= 1'b0;
      nflag_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      drop_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            if (issueMulDiv) begin
              opLatched_q <= opcode;
              cnt_q       <= CNT_LOAD;
              state_q     <= S_WAIT;
            end else if (issueNoCapture) begin
              done_q <= 1'b1;
            end else begin
              zhi_q  <= c_in[63:32];
              zlo_q  <= c_in[31:0];
              done_q <= 1'b1;
`ifdef ALU_RESULT_ZFLAG_EN
              zflag_q <= (c_in == 64'd0);
              nflag_q <= c_in[31];
`endif
            end
          end
        end
        S_WAIT: begin
          if (issue) begin
            drop_q <= 1'b1;
          end
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            zhi_q <= c_in[63:32];
            zlo_q <= c_in[31:0];
            if (latchedMulDiv) begin
              hi_q <= c_in[63:32];
              lo_q <= c_in[31:0];
            end
`ifdef ALU_RESULT_ZFLAG_EN
            zflag_q <= (c_in == 64'd0);
            nflag_q <= c_in[63];
`endif
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath bus mux: fixed priority zlo > zhi > lo > hi, zero when idle.
  always_comb begin
    bus_out = 32'd0;
    if (zlo_oe) begin
      bus_out = zlo_q;
    end else if (zhi_oe) begin
      bus_out = zhi_q;
    end else if (lo_oe) begin
      bus_out = lo_q;
    end else if (hi_oe) begin
      bus_out = hi_q;
    end
  end

  assign bus_drv    = zlo_oe | zhi_oe | lo_oe | hi_oe;
  assign busy       = (state_q == S_WAIT);
  assign done       = done_q;
  assign issue_drop = drop_q;
  assign zhi        = zhi_q;
  assign zlo        = zlo_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
`ifdef ALU_RESULT_ZFLAG_EN
  assign zflag      = zflag_q;
  assign nflag      = nflag_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed bench for alu_result_stage.
// A vector table covers the single-cycle ops; hand-written sequences
// cover mul/div settle timing, dropped issues, mid-wait reset and the bus.
// Flag checks are compiled in when ALU_RESULT_ZFLAG_EN is defined.
module tb_alu_result_stage;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NOP  = 5'b11001;
   localparam logic [4:0] OP_HALT = 5'b11010;

   logic        clock;
   logic        clr;
   logic        issue;
   logic [4:0]  opcode;
   logic [63:0] cIn;
   logic        busy;
   logic        done;
   logic        issueDrop;
   logic [31:0] zhi;
   logic [31:0] zlo;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        zloOe;
   logic        zhiOe;
   logic        loOe;
   logic        hiOe;
   logic [31:0] busOut;
   logic        busDrv;
`ifdef ALU_RESULT_ZFLAG_EN
   logic        zflag;
   logic        nflag;
`endif

   int checkCount = 0;
   int errorCount = 0;

   typedef struct {
      logic [4:0]  op;
      logic [63:0] c;
      logic [31:0] expZhi;
      logic [31:0] expZlo;
      logic        expZf;
      logic        expNf;
   } vec_t;

   vec_t vecs [7];

   alu_result_stage dut (
      .clk        (clock),
      .clr        (clr),
      .issue      (issue),
      .opcode     (opcode),
      .c_in       (cIn),
      .busy       (busy),
      .done       (done),
      .issue_drop (issueDrop),
      .zhi        (zhi),
      .zlo        (zlo),
      .hi         (hi),
      .lo         (lo),
      .zlo_oe     (zloOe),
      .zhi_oe     (zhiOe),
      .lo_oe      (loOe),
      .hi_oe      (hiOe),
      .bus_out    (busOut),
      .bus_drv    (busDrv)
`ifdef ALU_RESULT_ZFLAG_EN
      ,
      .zflag      (zflag),
      .nflag      (nflag)
`endif
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Present one issue across a single rising edge; c_in stays driven.
   task automatic applyStimulus(input logic [4:0] op, input logic [63:0] c);
      issue  = 1'b1;
      opcode = op;
      cIn    = c;
      step();
      issue  = 1'b0;
   endtask

   // Compare one observed value against the bench's expectation.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Main directed sequence.
   initial begin
      vecs[0] = '{OP_ADD,  64'h0000_0000_0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b0, 1'b0};
      vecs[1] = '{OP_SUB,  64'hDEAD_BEEF_1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0};
      vecs[2] = '{OP_NOP,  64'hFFFF_FFFF_FFFF_FFFF, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0};
      vecs[3] = '{OP_HALT, 64'h0000_0000_0000_0000, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0};
      vecs[4] = '{OP_SUB,  64'h0000_0000_0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
      vecs[5] = '{OP_NOP,  64'h0000_0000_0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
      vecs[6] = '{OP_ADD,  64'h0000_0000_8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1};

      clr    = 1'b0;
      issue  = 1'b1;
      opcode = OP_ADD;
      cIn    = 64'h0000_0123_0000_0456;
      zloOe  = 1'b0;
      zhiOe  = 1'b0;
      loOe   = 1'b0;
      hiOe   = 1'b0;
      step();
      step();
      $display("[TB] reset with issue held high");
      checkOutput("reset zhi", 64'(zhi), 64'd0);
      checkOutput("reset zlo", 64'(zlo), 64'd0);
      checkOutput("reset hi", 64'(hi), 64'd0);
      checkOutput("reset lo", 64'(lo), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset drop", 64'(issueDrop), 64'd0);
      checkOutput("reset bus", {31'd0, busDrv, busOut}, 64'd0);
`ifdef ALU_RESULT_ZFLAG_EN
      checkOutput("reset zflag", 64'(zflag), 64'd0);
      checkOutput("reset nflag", 64'(nflag), 64'd0);
`endif
      clr   = 1'b1;
      issue = 1'b0;
      step();

      $display("[TB] single-cycle vector table");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].op, vecs[i].c);
         checkOutput($sformatf("vec%0d zhi", i), 64'(zhi), 64'(vecs[i].expZhi));
         checkOutput($sformatf("vec%0d zlo", i), 64'(zlo), 64'(vecs[i].expZlo));
         checkOutput($sformatf("vec%0d hi", i), 64'(hi), 64'd0);
         checkOutput($sformatf("vec%0d lo", i), 64'(lo), 64'd0);
         checkOutput($sformatf("vec%0d done", i), 64'(done), 64'd1);
         checkOutput($sformatf("vec%0d busy", i), 64'(busy), 64'd0);
`ifdef ALU_RESULT_ZFLAG_EN
         checkOutput($sformatf("vec%0d zflag", i), 64'(zflag), 64'(vecs[i].expZf));
         checkOutput($sformatf("vec%0d nflag", i), 64'(nflag), 64'(vecs[i].expNf));
`endif
         step();
         checkOutput($sformatf("vec%0d done low", i), 64'(done), 64'd0);
      end

      $display("[TB] mul settle and capture edge");
      applyStimulus(OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("mul busy E0", 64'(busy), 64'd1);
      checkOutput("mul done E0", 64'(done), 64'd0);
      for (int e = 1; e <= 3; e++) begin
         step();
         checkOutput($sformatf("mul busy E%0d", e), 64'(busy), 64'd1);
         checkOutput($sformatf("mul zlo E%0d", e), 64'(zlo), 64'h8000_0000);
         checkOutput($sformatf("mul hi E%0d", e), 64'(hi), 64'd0);
         checkOutput($sformatf("mul done E%0d", e), 64'(done), 64'd0);
      end
      cIn = 64'h0000_0001_0000_0002;
      step();
      checkOutput("mul busy E4", 64'(busy), 64'd0);
      checkOutput("mul done E4", 64'(done), 64'd1);
      checkOutput("mul hi", 64'(hi), 64'd1);
      checkOutput("mul lo", 64'(lo), 64'd2);
      checkOutput("mul zhi", 64'(zhi), 64'd1);
      checkOutput("mul zlo", 64'(zlo), 64'd2);
`ifdef ALU_RESULT_ZFLAG_EN
      checkOutput("mul zflag", 64'(zflag), 64'd0);
      checkOutput("mul nflag", 64'(nflag), 64'd0);
`endif
      step();
      checkOutput("mul done low", 64'(done), 64'd0);

      $display("[TB] div with an issue dropped while busy");
      applyStimulus(OP_DIV, 64'h0000_0003_0000_0007);
      step();
      issue  = 1'b1;
      opcode = OP_ADD;
      step();
      issue  = 1'b0;
      opcode = OP_DIV;
      checkOutput("drop pulse", 64'(issueDrop), 64'd1);
      checkOutput("drop busy", 64'(busy), 64'd1);
      checkOutput("drop zlo", 64'(zlo), 64'd2);
      checkOutput("drop hi", 64'(hi), 64'd1);
      step();
      checkOutput("drop pulse low", 64'(issueDrop), 64'd0);
      checkOutput("drop still busy", 64'(busy), 64'd1);
      step();
      checkOutput("div done", 64'(done), 64'd1);
      checkOutput("div busy", 64'(busy), 64'd0);
      checkOutput("div hi rem", 64'(hi), 64'd3);
      checkOutput("div lo quot", 64'(lo), 64'd7);
      checkOutput("div zhi", 64'(zhi), 64'd3);
      checkOutput("div zlo", 64'(zlo), 64'd7);
      step();

      $display("[TB] reset in the middle of a mul wait");
      applyStimulus(OP_MUL, 64'h0000_0005_0000_0006);
      step();
      clr = 1'b0;
      step();
      checkOutput("midrst busy", 64'(busy), 64'd0);
      checkOutput("midrst hi", 64'(hi), 64'd0);
      checkOutput("midrst lo", 64'(lo), 64'd0);
      checkOutput("midrst zlo", 64'(zlo), 64'd0);
      checkOutput("midrst done", 64'(done), 64'd0);
      clr = 1'b1;
      for (int e = 3; e <= 5; e++) begin
         step();
         checkOutput($sformatf("midrst done E%0d", e), 64'(done), 64'd0);
         checkOutput($sformatf("midrst hi E%0d", e), 64'(hi), 64'd0);
      end
      applyStimulus(OP_ADD, 64'h0000_0000_0000_0009);
      checkOutput("post-rst add zlo", 64'(zlo), 64'd9);
      checkOutput("post-rst add done", 64'(done), 64'd1);

      $display("[TB] bus mux priority");
      applyStimulus(OP_MUL, 64'h0000_0009_0000_0005);
      repeat (4) step();
      checkOutput("bus setup zlo", 64'(zlo), 64'd5);
      checkOutput("bus setup hi", 64'(hi), 64'd9);
      hiOe = 1'b1;
      #1;
      checkOutput("bus hi only", 64'(busOut), 64'd9);
      checkOutput("bus hi drv", 64'(busDrv), 64'd1);
      zloOe = 1'b1;
      #1;
      checkOutput("bus zlo+hi", 64'(busOut), 64'd5);
      zloOe = 1'b0;
      hiOe  = 1'b0;
      zhiOe = 1'b1;
      loOe  = 1'b1;
      #1;
      checkOutput("bus zhi+lo", 64'(busOut), 64'd9);
      zhiOe = 1'b0;
      #1;
      checkOutput("bus lo only", 64'(busOut), 64'd5);
      loOe = 1'b0;
      #1;
      checkOutput("bus none", 64'(busOut), 64'd0);
      checkOutput("bus none drv", 64'(busDrv), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
